pipe_collision_checker: RTL and testbench
=========================================

Name: pipe_collision_checker

Overview:
Consumer of the pipe position bus: reads the four pipe X/Y coordinates and the bird position, and decides whether the bird has hit a pipe, the ground or the ceiling. Runs a time-multiplexed scan of one pipe per cycle, triggered once per frame by a request pulse. Produces a sticky collision flag that the game-state FSM uses to enter END_SCREEN.

Parameters:
NUM_PIPES, 4, number of pipes scanned (1..4); pipes at index NUM_PIPES and above are ignored
PIPE_SIZE_X, 78, pipe width in pixels
GAP_SIZE, 120, vertical opening height in pixels; the opening spans pipeY to pipeY+GAP_SIZE-1
BIRD_W, 34, bird hitbox width in pixels
BIRD_H, 24, bird hitbox height in pixels
PLAY_HEIGHT, 420, play-area height in pixels; the ground is at y = PLAY_HEIGHT
HITBOX_MARGIN, 4, hitbox shrink in pixels per side (used only with the optional feature)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
check_req  in  1  single-cycle request to start a scan (one per frame)
game_state  in  4  one-hot: START_SCREEN=0001, IN_GAME=0010, PAUSE=0100, END_SCREEN=1000
birdX, birdY  in  32 signed  bird top-left corner
pipeX_1..pipeX_4  in  32 signed  pipe left edges
pipeY_1..pipeY_4  in  32 signed  gap top edges
check_busy  out  1  high while a scan is in progress
check_done  out  1  single-cycle pulse when a scan completes
collision  out  1  sticky hit flag
hit_pipe  out  2  index of the lowest-numbered pipe hit; valid while collision is high
hit_bound  out  1  sticky flag: the hit was ground or ceiling

Behaviour:
- Reset (async): FSM = IDLE; all outputs 0; snapshot registers 0.
- FSM states and transitions:
  - IDLE -> SNAP when check_req=1.
  - SNAP: latch birdX, birdY, all pipeX/pipeY; clear the scan index. -> SCAN.
  - SCAN: test pipe[idx] each cycle; idx increments. -> BOUND after idx = NUM_PIPES-1.
  - BOUND: run the ground/ceiling test. -> DONE.
  - DONE: assert check_done for 1 cycle. -> IDLE.
- Latency: check_req in cycle 0 gives check_done in cycle NUM_PIPES+3 (cycle 7 for 4 pipes).
- check_busy is high in every state except IDLE.
- check_req while busy is ignored and not queued.
- Input changes after SNAP do not affect the result.
- Pipe hit test (signed 32-bit arithmetic, strict inequalities; touching edges is not a hit). A hit requires both:
  - birdX+BIRD_W > pipeX and birdX < pipeX+PIPE_SIZE_X;
  - birdY < pipeY or birdY+BIRD_H > pipeY+GAP_SIZE.
- Off-screen pipes (pipeX+PIPE_SIZE_X <= 0) fail the X test naturally; no special case is needed.
- Bound test: birdY < 0 (ceiling) or birdY+BIRD_H >= PLAY_HEIGHT (ground).
- Updates happen only when game_state=IN_GAME at SNAP time. Otherwise the scan still runs to DONE and pulses check_done, but leaves the flags unchanged.
- First hit wins:
  - Once collision=1, later hits do not change hit_pipe or hit_bound.
  - When several pipes hit in one scan, the lowest index is reported.
  - When a pipe hit and a bound hit occur in the same scan, the pipe is reported (hit_bound=0).
- Clearing:
  - game_state=START_SCREEN clears collision, hit_pipe and hit_bound in any state, at any time. An in-flight scan is aborted to IDLE with no check_done pulse.
  - PAUSE and END_SCREEN hold the flags.
- Reset mid-scan returns the FSM to IDLE immediately; no check_done is produced.

Optional Feature:
HITBOX_MARGIN_EN: when defined, the bird hitbox is shrunk by HITBOX_MARGIN on every side: X from birdX+M to birdX+BIRD_W-M, Y likewise. This applies to both the pipe test and the bound test. When undefined, the full BIRD_W×BIRD_H box is used and HITBOX_MARGIN is unused.

Decomposition:
- Shared package flappy_pkg holds:
  - the game_state one-hot localparams;
  - PIPE_SIZE_X, PIPE_SEPARATION and PLAY_HEIGHT, reused by the pipe generator;
  - the FSM state encoding.
- One combinational sub-module, aabb_overlap, takes two rectangles (x, y, w, h, signed 32) and outputs overlap with strict edges. The pipe test instantiates it twice, once for the top pipe and once for the bottom pipe.

Test Plan:
- Clear pass: IN_GAME, bird (100,200), pipe0 (300,150), other pipes at X=700+ → check_done at cycle 7; collision=0.
- Top-pipe hit: bird (100,140), pipe2 (90,150) → collision=1, hit_pipe=2, hit_bound=0.
- Edge touch: bird (100,150), pipe0 X=134 (birdX+BIRD_W=pipeX) → no hit. With pipe0 X=133 and birdY=149 → hit.
- Ground hit: birdY=396 (396+24=420) → collision=1, hit_bound=1. With birdY=395 → no hit.
- Multi-hit and sticky: pipes 1 and 3 both overlapping → hit_pipe=1. A next-frame scan with pipe3 only hit leaves hit_pipe=1. START_SCREEN then clears all flags.
- Gating and abort:
  - Request in PAUSE with an overlapping bird → done pulse, collision stays 0.
  - START_SCREEN asserted during SCAN → busy drops next cycle, no done pulse.
  - Request while busy → ignored.

Source files
------------

// File: rtl/flappy_pkg.sv
// Shared constants for the flappy game blocks: game-state encoding, play-area
// and pipe geometry, bird hitbox size, and the collision checker FSM states.
// The collision checker's optional hitbox shrink is enabled by HITBOX_MARGIN_EN.
package flappy_pkg;

    // One-hot game_state encoding driven by the game-state FSM
    localparam logic [3:0] GS_START_SCREEN = 4'b0001;
    localparam logic [3:0] GS_IN_GAME      = 4'b0010;
    localparam logic [3:0] GS_PAUSE        = 4'b0100;
    localparam logic [3:0] GS_END_SCREEN   = 4'b1000;

    // Geometry shared with the pipe generator
    localparam int PIPE_SIZE_X     = 78;
    localparam int PIPE_SEPARATION = 200;
    localparam int PLAY_HEIGHT     = 420;

    // Collision geometry
    localparam int GAP_SIZE      = 120;
    localparam int BIRD_W        = 34;
    localparam int BIRD_H        = 24;
    localparam int HITBOX_MARGIN = 4;

    // Height used for the open-ended top and bottom pipe rectangles; large
    // enough to cover the play area, small enough to keep sums in 32 bits.
    localparam int PIPE_SPAN = 32'sh4000_0000;

    typedef enum logic [2:0] {
        CHK_IDLE  = 3'd0,
        CHK_SNAP  = 3'd1,
        CHK_SCAN  = 3'd2,
        CHK_BOUND = 3'd3,
        CHK_DONE  = 3'd4
    } chk_state_t;

endpackage

// File: rtl/aabb_overlap.sv
// Axis-aligned rectangle overlap with strict edges: rectangles that only
// share an edge do not overlap. All values are signed 32-bit pixels.
module aabb_overlap (
    input  logic signed [31:0] a_x,
    input  logic signed [31:0] a_y,
    input  logic signed [31:0] a_w,
    input  logic signed [31:0] a_h,
    input  logic signed [31:0] b_x,
    input  logic signed [31:0] b_y,
    input  logic signed [31:0] b_w,
    input  logic signed [31:0] b_h,
    output logic               overlap
);

    // Interval overlap on both axes, each edge compared strictly
    always_comb begin
        overlap = (a_x < b_x + b_w) && (b_x < a_x + a_w) &&
                  (a_y < b_y + b_h) && (b_y < a_y + a_h);
    end

endmodule

// File: rtl/pipe_collision_checker.sv
// Per-frame bird collision check against the pipes, the ground and the ceiling.
// One pipe is tested per cycle from a snapshot taken at request time.
// Optional macro HITBOX_MARGIN_EN shrinks the bird hitbox on every side.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for check_req
// SNAP  | latch bird/pipe coordinates and the in-game qualifier
// SCAN  | test pipe[idx], one pipe per cycle
// BOUND | test ground and ceiling
// DONE  | pulse check_done
import flappy_pkg::*;

module pipe_collision_checker #(
    parameter int NUM_PIPES = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               check_req,
    input  logic [3:0]         game_state,
    input  logic signed [31:0] birdX,
    input  logic signed [31:0] birdY,
    input  logic signed [31:0] pipeX_1,
    input  logic signed [31:0] pipeX_2,
    input  logic signed [31:0] pipeX_3,
    input  logic signed [31:0] pipeX_4,
    input  logic signed [31:0] pipeY_1,
    input  logic signed [31:0] pipeY_2,
    input  logic signed [31:0] pipeY_3,
    input  logic signed [31:0] pipeY_4,
    output logic               check_busy,
    output logic               check_done,
    output logic               collision,
    output logic [1:0]         hit_pipe,
    output logic               hit_bound
);

`ifdef HITBOX_MARGIN_EN
    localparam int HB_M = HITBOX_MARGIN;
`else
    localparam int HB_M = 0;
`endif

    localparam logic [1:0] LAST_IDX = 2'(NUM_PIPES - 1);

    chk_state_t         state_q, state_d;
    logic [1:0]         idx_q, idx_d;
    logic               upd_q, upd_d;
    logic signed [31:0] bird_x_q, bird_x_d;
    logic signed [31:0] bird_y_q, bird_y_d;
    logic signed [31:0] pipe_x_q [4];
    logic signed [31:0] pipe_x_d [4];
    logic signed [31:0] pipe_y_q [4];
    logic signed [31:0] pipe_y_d [4];
    logic               collision_q, collision_d;
    logic [1:0]         hit_pipe_q, hit_pipe_d;
    logic               hit_bound_q, hit_bound_d;

    logic signed [31:0] pipe_x_in [4];
    logic signed [31:0] pipe_y_in [4];
    logic signed [31:0] hb_x, hb_y, hb_w, hb_h;
    logic signed [31:0] cur_px, cur_py;
    logic signed [31:0] top_y, bot_y;
    logic               top_hit, bot_hit, pipe_hit, bound_hit;

    // Gather the pipe bus into arrays so the scan can index it
    always_comb begin
        pipe_x_in[0] = pipeX_1;
        pipe_x_in[1] = pipeX_2;
        pipe_x_in[2] = pipeX_3;
        pipe_x_in[3] = pipeX_4;
        pipe_y_in[0] = pipeY_1;
        pipe_y_in[1] = pipeY_2;
        pipe_y_in[2] = pipeY_3;
        pipe_y_in[3] = pipeY_4;
    end

    // Bird hitbox and current pipe geometry from the snapshot
    always_comb begin
        hb_x   = bird_x_q + HB_M;
        hb_y   = bird_y_q + HB_M;
        hb_w   = BIRD_W - 2 * HB_M;
        hb_h   = BIRD_H - 2 * HB_M;
        cur_px = pipe_x_q[idx_q];
        cur_py = pipe_y_q[idx_q];
        // Top pipe ends just above the gap, bottom pipe starts just below it
        top_y  = cur_py - PIPE_SPAN;
        bot_y  = cur_py + GAP_SIZE;
    end

    aabb_overlap u_top_pipe (
        .a_x     (hb_x),
        .a_y     (hb_y),
        .a_w     (hb_w),
        .a_h     (hb_h),
        .b_x     (cur_px),
        .b_y     (top_y),
        .b_w     (PIPE_SIZE_X),
        .b_h     (PIPE_SPAN),
        .overlap (top_hit)
    );

    aabb_overlap u_bot_pipe (
        .a_x     (hb_x),
        .a_y     (hb_y),
        .a_w     (hb_w),
        .a_h     (hb_h),
        .b_x     (cur_px),
        .b_y     (bot_y),
        .b_w     (PIPE_SIZE_X),
        .b_h     (PIPE_SPAN),
        .overlap (bot_hit)
    );

    // Pipe hit for the current index, and the ground/ceiling test
    always_comb begin
        pipe_hit  = top_hit || bot_hit;
        bound_hit = (hb_y < 0) || (hb_y + hb_h >= PLAY_HEIGHT);
    end

    // Next-state, snapshot and sticky-flag logic; START_SCREEN overrides all
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        upd_d       = upd_q;
        bird_x_d    = bird_x_q;
        bird_y_d    = bird_y_q;
        pipe_x_d    = pipe_x_q;
        pipe_y_d    = pipe_y_q;
        collision_d = collision_q;
        hit_pipe_d  = hit_pipe_q;
        hit_bound_d = hit_bound_q;

        case (state_q)
            CHK_IDLE: begin
                if (check_req) begin
                    state_d = CHK_SNAP;
                end
            end
            CHK_SNAP: begin
                bird_x_d = birdX;
                bird_y_d = birdY;
                pipe_x_d = pipe_x_in;
                pipe_y_d = pipe_y_in;
                idx_d    = 2'd0;
                upd_d    = (game_state == GS_IN_GAME);
                state_d  = CHK_SCAN;
            end
            CHK_SCAN: begin
                // Ascending scan plus the sticky flag gives lowest-index priority
                if (upd_q && !collision_q && pipe_hit) begin
                    collision_d = 1'b1;
                    hit_pipe_d  = idx_q;
                    hit_bound_d = 1'b0;
                end
                if (idx_q == LAST_IDX) begin
                    state_d = CHK_BOUND;
                end else begin
                    idx_d = idx_q + 2'd1;
                end
            end
            CHK_BOUND: begin
                // A pipe hit earlier in this scan already owns the flags
                if (upd_q && !collision_q && bound_hit) begin
                    collision_d = 1'b1;
                    hit_bound_d = 1'b1;
                end
                state_d = CHK_DONE;
            end
            CHK_DONE: begin
                state_d = CHK_IDLE;
            end
            default: begin
                state_d = CHK_IDLE;
            end
        endcase

        if (game_state == GS_START_SCREEN) begin
            state_d     = CHK_IDLE;
            collision_d = 1'b0;
            hit_pipe_d  = 2'd0;
            hit_bound_d = 1'b0;
        end
    end

    // State, snapshot and flag registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= CHK_IDLE;
            idx_q       <= 2'd0;
            upd_q       <= 1'b0;
            bird_x_q    <= '0;
            bird_y_q    <= '0;
            for (int i = 0; i < 4; i++) begin
                pipe_x_q[i] <= '0;
                pipe_y_q[i] <= '0;
            end
            collision_q <= 1'b0;
            hit_pipe_q  <= 2'd0;
            hit_bound_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            upd_q       <= upd_d;
            bird_x_q    <= bird_x_d;
            bird_y_q    <= bird_y_d;
            pipe_x_q    <= pipe_x_d;
            pipe_y_q    <= pipe_y_d;
            collision_q <= collision_d;
            hit_pipe_q  <= hit_pipe_d;
            hit_bound_q <= hit_bound_d;
        end
    end

    assign check_busy = (state_q != CHK_IDLE);
    assign check_done = (state_q == CHK_DONE);
    assign collision  = collision_q;
    assign hit_pipe   = hit_pipe_q;
    assign hit_bound  = hit_bound_q;

endmodule

// File: tb/tb_pipe_collision_checker.sv
// Testbench for pipe_collision_checker: a vector table of per-frame scans
// with expected results queued at request time and compared at check_done,
// plus hand-written abort, busy-request, snapshot and reset sequences.
module tb_pipe_collision_checker;

    localparam logic [3:0] START = 4'b0001;
    localparam logic [3:0] IG    = 4'b0010;
    localparam logic [3:0] PAUSE = 4'b0100;
    localparam logic [3:0] ENDS  = 4'b1000;
    localparam int LAT = 7;
    localparam int MAX_WAIT = 30;

    logic               clk = 1'b0;
    logic               rst;
    logic               check_req;
    logic [3:0]         game_state;
    logic signed [31:0] birdX, birdY;
    logic signed [31:0] pipeX_1, pipeX_2, pipeX_3, pipeX_4;
    logic signed [31:0] pipeY_1, pipeY_2, pipeY_3, pipeY_4;
    logic               check_busy, check_done, collision, hit_bound;
    logic [1:0]         hit_pipe;

    pipe_collision_checker dut (
        .clk        (clk),
        .rst        (rst),
        .check_req  (check_req),
        .game_state (game_state),
        .birdX      (birdX),
        .birdY      (birdY),
        .pipeX_1    (pipeX_1),
        .pipeX_2    (pipeX_2),
        .pipeX_3    (pipeX_3),
        .pipeX_4    (pipeX_4),
        .pipeY_1    (pipeY_1),
        .pipeY_2    (pipeY_2),
        .pipeY_3    (pipeY_3),
        .pipeY_4    (pipeY_4),
        .check_busy (check_busy),
        .check_done (check_done),
        .collision  (collision),
        .hit_pipe   (hit_pipe),
        .hit_bound  (hit_bound)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic signed [31:0] bx;
        logic signed [31:0] by;
        logic [3:0][31:0]   px;
        logic [3:0]         gs;
        logic               clr;
        logic               col;
        logic [1:0]         pipe;
        logic               bnd;
    } vec_t;

    typedef struct packed {
        logic       col;
        logic [1:0] pipe;
        logic       bnd;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic vec_t mk(input int bx, input int by, input int p0, input int p1,
                                input int p2, input int p3, input logic [3:0] gs,
                                input logic clr, input logic col, input logic [1:0] pipe,
                                input logic bnd);
        vec_t v;
        v.bx = bx;  v.by = by;
        v.px[0] = p0; v.px[1] = p1; v.px[2] = p2; v.px[3] = p3;
        v.gs = gs;  v.clr = clr;
        v.col = col; v.pipe = pipe; v.bnd = bnd;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t v);
        birdX   = v.bx;
        birdY   = v.by;
        pipeX_1 = v.px[0];
        pipeX_2 = v.px[1];
        pipeX_3 = v.px[2];
        pipeX_4 = v.px[3];
        pipeY_1 = 150; pipeY_2 = 150; pipeY_3 = 150; pipeY_4 = 150;
        game_state = v.gs;
    endtask

    task automatic clear_flags();
        game_state = START;
        tick();
        chk("clear_collision", collision, 0);
    endtask

    // Pulse check_req and wait (bounded) for check_done; returns cycles taken
    task automatic do_scan(output int lat);
        check_req = 1'b1;
        tick();
        check_req = 1'b0;
        lat = 1;
        while (check_done !== 1'b1 && lat < MAX_WAIT) begin
            tick();
            lat++;
        end
    endtask

    task automatic run_vec(input int n, input vec_t v);
        int   lat;
        exp_t e;
        if (v.clr) clear_flags();
        drive(v);
        e.col = v.col; e.pipe = v.pipe; e.bnd = v.bnd;
        sb.push_back(e);
        do_scan(lat);
        chk($sformatf("v%0d_latency", n), lat, LAT);
        chk($sformatf("v%0d_done", n), check_done, 1);
        e = sb.pop_front();
        chk($sformatf("v%0d_collision", n), collision, e.col);
        chk($sformatf("v%0d_hit_bound", n), hit_bound, e.bnd);
        if (e.col && !e.bnd) chk($sformatf("v%0d_hit_pipe", n), hit_pipe, e.pipe);
        tick();
        chk($sformatf("v%0d_done_drop", n), check_done, 0);
        chk($sformatf("v%0d_idle", n), check_busy, 0);
    endtask

    initial begin
        int lat;
        int dones;
        int first_done;

        rst = 1'b1;
        check_req = 1'b0;
        drive(mk(0, 0, 0, 0, 0, 0, IG, 0, 0, 0, 0));
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", check_busy, 0);
        chk("rst_done", check_done, 0);
        chk("rst_collision", collision, 0);
        chk("rst_hit_pipe", hit_pipe, 0);
        chk("rst_hit_bound", hit_bound, 0);
        rst = 1'b0;
        tick();

        //            bx   by    p0   p1   p2   p3    gs  clr col pipe bnd
        vecs.push_back(mk(100, 200, 300, 800, 900, 1000, IG,    1, 0, 0, 0)); // clear pass
        vecs.push_back(mk(100, 140, 300, 800,  90, 1000, IG,    1, 1, 2, 0)); // top pipe 2
        vecs.push_back(mk(100, 150, 134, 800, 900, 1000, IG,    1, 0, 0, 0)); // X edge touch
        vecs.push_back(mk(100, 149, 133, 800, 900, 1000, IG,    1, 1, 0, 0)); // 1px overlap
        vecs.push_back(mk(100, 396, 300, 800, 900, 1000, IG,    1, 1, 0, 1)); // ground
        vecs.push_back(mk(100, 395, 300, 800, 900, 1000, IG,    1, 0, 0, 0)); // above ground
        vecs.push_back(mk(100, 260, 300, 100, 900, 1000, IG,    1, 1, 1, 0)); // bottom pipe 1
        vecs.push_back(mk(100, 140, 300,  90, 900,  110, IG,    1, 1, 1, 0)); // pipes 1 and 3
        vecs.push_back(mk(100, 140, 300, 800, 900,  110, IG,    0, 1, 1, 0)); // sticky
        vecs.push_back(mk(100, 400, 300, 800,  90, 1000, IG,    1, 1, 2, 0)); // pipe beats ground
        vecs.push_back(mk(100,  -1, 300, 800, 900, 1000, IG,    1, 1, 0, 1)); // ceiling
        vecs.push_back(mk(100, 140, 300, 800,  90, 1000, IG,    0, 1, 0, 1)); // sticky bound
        vecs.push_back(mk(100,   0, 300, 800, 900, 1000, IG,    1, 0, 0, 0)); // ceiling edge
        vecs.push_back(mk(  0, 100, -78, 800, 900, 1000, IG,    1, 0, 0, 0)); // off-screen pipe
        vecs.push_back(mk(100, 140, 300, 800,  90, 1000, PAUSE, 1, 0, 0, 0)); // gated by pause
        vecs.push_back(mk(100, 140, 300, 800,  90, 1000, IG,    1, 1, 2, 0));
        vecs.push_back(mk(100, 396, 300,  90, 900, 1000, ENDS,  0, 1, 2, 0)); // end screen holds

        foreach (vecs[i]) run_vec(i, vecs[i]);

        // START_SCREEN during SCAN aborts with no done pulse
        clear_flags();
        drive(mk(100, 140, 300, 800, 90, 1000, IG, 0, 0, 0, 0));
        check_req = 1'b1;
        tick();
        check_req = 1'b0;
        tick();
        tick();
        chk("abort_busy_before", check_busy, 1);
        game_state = START;
        tick();
        chk("abort_busy", check_busy, 0);
        chk("abort_collision", collision, 0);
        game_state = IG;
        dones = 0;
        for (int c = 0; c < 12; c++) begin
            if (check_done) dones++;
            tick();
        end
        chk("abort_no_done", dones, 0);

        // A request while busy is neither served nor queued
        clear_flags();
        drive(mk(100, 200, 300, 800, 900, 1000, IG, 0, 0, 0, 0));
        check_req = 1'b1;
        dones = 0;
        first_done = 0;
        for (int c = 1; c <= 25; c++) begin
            tick();
            check_req = (c == 3);
            if (check_done) begin
                dones++;
                if (first_done == 0) first_done = c;
            end
        end
        check_req = 1'b0;
        chk("busy_req_first_done", first_done, LAT);
        chk("busy_req_done_count", dones, 1);

        // Inputs changed after SNAP are not seen
        clear_flags();
        drive(mk(100, 200, 300, 800, 900, 1000, IG, 0, 0, 0, 0));
        check_req = 1'b1;
        tick();
        check_req = 1'b0;
        tick();
        birdY = 140;
        pipeX_1 = 90;
        pipeX_3 = 90;
        lat = 2;
        while (check_done !== 1'b1 && lat < MAX_WAIT) begin
            tick();
            lat++;
        end
        chk("snap_latency", lat, LAT);
        chk("snap_collision", collision, 0);
        tick();

        // Async reset mid-scan drops everything at once
        run_vec(100, mk(100, 140, 300, 800, 90, 1000, IG, 1, 1, 2, 0));
        check_req = 1'b1;
        tick();
        check_req = 1'b0;
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        chk("rst_mid_busy", check_busy, 0);
        chk("rst_mid_collision", collision, 0);
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (check_done) dones++;
        end
        chk("rst_mid_no_done", dones, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
